// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-timing source for the display pipeline. Scans DrawX/DrawY over the
//   full raster (visible area plus porches and sync), flags active video on
//   `blank`, and generates active-low hs/vs. The sync outputs are delayed by
//   SYNC_DELAY registers so they line up with the renderers' registered RGB.
//   The coordinates and blank are never delayed. Line/frame strobes and a
//   frame counter are provided for animation timing.
//
// Ports:
//   vga_clk      in   pixel clock, rising edge active
//   reset_n      in   asynchronous active-low reset
//   DrawX        out  [9:0] current pixel column (horizontal counter)
//   DrawY        out  [9:0] current pixel row (vertical counter)
//   blank        out  1 = active video, 0 = blanking
//   hs           out  horizontal sync, active low, delayed SYNC_DELAY clocks
//   vs           out  vertical sync, active low, delayed SYNC_DELAY clocks
//   line_start   out  one-cycle pulse while DrawX == 0
//   frame_start  out  one-cycle pulse while DrawX == 0 and DrawY == 0
//   frame_count  out  [FC_W-1:0] frame starts since reset, wrapping
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1,
  parameter int FC_W       = 16
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Sync windows, compared in int so an end bound of 1024 cannot alias to 0.
  localparam int HS_BEG = H_VISIBLE + H_FP;
  localparam int HS_END = H_VISIBLE + H_FP + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FP;
  localparam int VS_END = V_VISIBLE + V_FP + V_SYNC;

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       blank_nxt;
  logic       line_nxt;
  logic       frame_nxt;
  logic       hs_raw;
  logic       vs_raw;

  // Next-state counter values. The strobes are derived from these rather
  // than from the current registers so that, once registered, they refer to
  // the same pixel as DrawX/DrawY on the same cycle.
  always_comb begin
    x_wrap    = (DrawX == H_LAST);
    y_wrap    = (DrawY == V_LAST);
    x_nxt     = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_nxt     = DrawY;
    if (x_wrap) begin
      y_nxt   = y_wrap ? 10'd0 : DrawY + 10'd1;
    end
    blank_nxt = (int'(x_nxt) < H_VISIBLE) && (int'(y_nxt) < V_VISIBLE);
    line_nxt  = (x_nxt == 10'd0);
    frame_nxt = line_nxt && (y_nxt == 10'd0);
  end

  // Stage p0: raster counters and aligned strobes. Reset parks the counters
  // on the last pixel of the frame so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= blank_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
      if (frame_nxt) begin
        frame_count <= frame_count + FC_W'(1);
      end
    end
  end

  // Undelayed sync decoded from the current counters; vs is held for the
  // whole of each sync line because it depends on DrawY only.
  always_comb begin
    hs_raw = !((int'(DrawX) >= HS_BEG) && (int'(DrawX) < HS_END));
    vs_raw = !((int'(DrawY) >= VS_BEG) && (int'(DrawY) < VS_END));
  end

  // Stage p1..pN: sync-only delay chain. Bit 0 is the first register; the
  // MSB drives the output. Resets to the inactive (high) level.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_comb
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_sync_dly
      logic [SYNC_DELAY-1:0] hs_p;
      logic [SYNC_DELAY-1:0] vs_p;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_p <= '1;
          vs_p <= '1;
        end else begin
          hs_p <= (hs_p << 1) | SYNC_DELAY'(hs_raw);
          vs_p <= (vs_p << 1) | SYNC_DELAY'(vs_raw);
        end
      end

      assign hs = hs_p[SYNC_DELAY-1];
      assign vs = vs_p[SYNC_DELAY-1];
    end
  endgenerate

  // Counters are 10 bits wide; larger rasters or delay depths outside the
  // supported range are flagged while simulating.
  always_ff @(posedge vga_clk) begin
    assert ((H_TOTAL <= 1024) && (V_TOTAL <= 1024) &&
            (SYNC_DELAY >= 0) && (SYNC_DELAY <= 4))
      else $error("vga_timing_gen: illegal timing parameters H_TOTAL=%0d V_TOTAL=%0d SYNC_DELAY=%0d",
                  H_TOTAL, V_TOTAL, SYNC_DELAY);
  end

endmodule
